// File: rtl/occupancy_grid_reader.sv
// rtl/occupancy_grid_reader.sv - bilinear occupancy grid query with x/y gradients
//
// Serves one sub-cell map query at a time for the scan matcher. The four cells
// around (xi,yi) are fetched over the grid's synchronous read port, then the
// interpolated occupancy and its x/y gradients are computed and returned.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   req_valid/req_ready          query handshake; point_x/point_y are fixed point
//   grid_read/grid_x/grid_y      read strobe and cell address to the grid memory
//   grid_value                   signed cell data, valid one cycle after address
//   resp_valid/resp_ready        result handshake
//   value, grad_x, grad_y        signed results with FRAC_BITS fractional bits
//   out_of_bounds                query touches cells outside the grid
module occupancy_grid_reader #(
  parameter int WORD_SIZE = 8,
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int FRAC_BITS = 8,
  localparam int IXW      = $clog2(WIDTH),
  localparam int IYW      = $clog2(HEIGHT),
  localparam int F        = FRAC_BITS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [IXW+F-1:0]            point_x,
  input  logic [IYW+F-1:0]            point_y,
  output logic                        grid_read,
  output logic [IXW-1:0]              grid_x,
  output logic [IYW-1:0]              grid_y,
  input  logic signed [WORD_SIZE-1:0] grid_value,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic signed [WORD_SIZE+F-1:0] value,
  output logic signed [WORD_SIZE+F:0]   grad_x,
  output logic signed [WORD_SIZE+F:0]   grad_y,
  output logic                        out_of_bounds
);

  localparam int LW = WORD_SIZE + F;       // row interpolant width
  localparam int AW = WORD_SIZE + 2 * F;   // full bilinear accumulator width
  localparam int GW = WORD_SIZE + F + 1;   // gradient width
  localparam int DW = WORD_SIZE + 1;       // corner difference width

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH0  = 3'd1;
  localparam logic [2:0] S_FETCH1  = 3'd2;
  localparam logic [2:0] S_FETCH2  = 3'd3;
  localparam logic [2:0] S_FETCH3  = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_COMPUTE = 3'd6;
  localparam logic [2:0] S_RESPOND = 3'd7;

  logic [2:0]                  state;
  logic [IXW-1:0]              xi;
  logic [IYW-1:0]              yi;
  logic [F-1:0]                dx;
  logic [F-1:0]                dy;
  logic signed [WORD_SIZE-1:0] m00, m10, m01, m11;
  logic                        req_oob;

  // The right/top neighbour must exist, so the last row/column is already out.
  always_comb begin
    req_oob = (point_x[IXW+F-1:F] >= IXW'(WIDTH - 1)) ||
              (point_y[IYW+F-1:F] >= IYW'(HEIGHT - 1));
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESPOND);

  always_comb begin
    grid_read = 1'b0;
    grid_x    = '0;
    grid_y    = '0;
    case (state)
      S_FETCH0: begin grid_read = 1'b1; grid_x = xi;             grid_y = yi;             end
      S_FETCH1: begin grid_read = 1'b1; grid_x = xi + IXW'(1);   grid_y = yi;             end
      S_FETCH2: begin grid_read = 1'b1; grid_x = xi;             grid_y = yi + IYW'(1);   end
      S_FETCH3: begin grid_read = 1'b1; grid_x = xi + IXW'(1);   grid_y = yi + IYW'(1);   end
      default: ;
    endcase
  end

  // Interpolation datapath. Every operand is cast to the result width first;
  // the low bits of a two's-complement product/sum do not depend on operand
  // signedness, and the true results always fit, so no wider guard is needed.
  logic [F:0]           wx, wy;
  logic signed [LW-1:0] l0, l1;
  logic signed [AW-1:0] acc;
  logic signed [DW-1:0] dx0, dx1, dy0, dy1;
  logic signed [GW-1:0] gx_c, gy_c;

  always_comb begin
    wx   = {1'b1, {F{1'b0}}} - {1'b0, dx};
    wy   = {1'b1, {F{1'b0}}} - {1'b0, dy};
    l0   = LW'(wx) * LW'(m00) + LW'(dx) * LW'(m10);
    l1   = LW'(wx) * LW'(m01) + LW'(dx) * LW'(m11);
    acc  = AW'(wy) * AW'(l0) + AW'(dy) * AW'(l1);
    dx0  = DW'(m10) - DW'(m00);
    dx1  = DW'(m11) - DW'(m01);
    dy0  = DW'(m01) - DW'(m00);
    dy1  = DW'(m11) - DW'(m10);
    gx_c = GW'(wy) * GW'(dx0) + GW'(dy) * GW'(dx1);
    gy_c = GW'(wx) * GW'(dy0) + GW'(dx) * GW'(dy1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      xi            <= '0;
      yi            <= '0;
      dx            <= '0;
      dy            <= '0;
      m00           <= '0;
      m10           <= '0;
      m01           <= '0;
      m11           <= '0;
      value         <= '0;
      grad_x        <= '0;
      grad_y        <= '0;
      out_of_bounds <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            xi            <= point_x[IXW+F-1:F];
            yi            <= point_y[IYW+F-1:F];
            dx            <= point_x[F-1:0];
            dy            <= point_y[F-1:0];
            value         <= '0;
            grad_x        <= '0;
            grad_y        <= '0;
            out_of_bounds <= req_oob;
            state         <= req_oob ? S_RESPOND : S_FETCH0;
          end
        end
        S_FETCH0:  state <= S_FETCH1;
        // Read data lags its address by one cycle.
        S_FETCH1:  begin m00 <= grid_value; state <= S_FETCH2;  end
        S_FETCH2:  begin m10 <= grid_value; state <= S_FETCH3;  end
        S_FETCH3:  begin m01 <= grid_value; state <= S_CAPTURE; end
        S_CAPTURE: begin m11 <= grid_value; state <= S_COMPUTE; end
        S_COMPUTE: begin
          value  <= LW'(acc >>> F);
          grad_x <= gx_c;
          grad_y <= gy_c;
          state  <= S_RESPOND;
        end
        S_RESPOND: if (resp_ready) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_occupancy_grid_reader.sv
// tb/tb_occupancy_grid_reader.sv - scoreboard bench for occupancy_grid_reader
module tb_occupancy_grid_reader;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [13:0]        point_x = '0;
  logic [13:0]        point_y = '0;
  logic               grid_read;
  logic [5:0]         grid_x;
  logic [5:0]         grid_y;
  logic signed [7:0]  grid_value = '0;
  logic               resp_valid;
  logic               resp_ready = 1'b1;
  logic signed [15:0] value;
  logic signed [16:0] grad_x;
  logic signed [16:0] grad_y;
  logic               out_of_bounds;

  always #5 clock = ~clock;

  occupancy_grid_reader dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .point_x(point_x), .point_y(point_y),
    .grid_read(grid_read), .grid_x(grid_x), .grid_y(grid_y), .grid_value(grid_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .value(value), .grad_x(grad_x), .grad_y(grad_y), .out_of_bounds(out_of_bounds)
  );

  typedef struct { int v; int gx; int gy; int oob; } exp_t;

  exp_t              sb[$];
  int                rd_q[$];
  int                reads_seen = 0;
  int                checks = 0;
  int                errors = 0;
  logic signed [7:0] mem [64][64];   // [y][x]

  // Grid memory: synchronous read, data one cycle after address.
  always @(posedge clock) begin
    if (grid_read) begin
      grid_value <= mem[grid_y][grid_x];
      rd_q.push_back(int'(grid_y) * 64 + int'(grid_x));
      reads_seen <= reads_seen + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int v, input int gx, input int gy, input int oob);
    exp_t e;
    e.v = v; e.gx = gx; e.gy = gy; e.oob = oob;
    return e;
  endfunction

  // Monitor: pops an expectation for every response the consumer takes.
  always @(negedge clock) begin
    if (reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got value %0d with no query pending", value);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("value", value, e.v);
        chk("grad_x", grad_x, e.gx);
        chk("grad_y", grad_y, e.gy);
        chk("oob", out_of_bounds, e.oob);
      end
    end
  end

  task automatic fill(input int v);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        mem[y][x] = 8'(v);
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    chk("accept_ready", req_ready, 1);
    @(posedge clock); #1;
  endtask

  // Returns the number of rising edges from the accept edge (inclusive) until resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 30) begin @(posedge clock); #1; lat++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 30) begin @(posedge clock); #1; n++; end
    chk("back_to_idle", req_ready, 1);
  endtask

  task automatic query(input int xq, input int yq, input exp_t e, input int exp_lat);
    int lat;
    sb.push_back(e);
    point_x = 14'(xq); point_y = 14'(yq); req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
    wait_resp(lat);
    chk("latency", lat, exp_lat);
    wait_idle();
  endtask

  initial begin
    int r0, lat;
    fill(0);

    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_grid_read", grid_read, 0);
    chk("rst_grid_x", grid_x, 0);
    chk("rst_value", value, 0);
    chk("rst_oob", out_of_bounds, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Uniform cells, (5.5,7.25): read order and constant interpolation
    fill(10);
    rd_q = {};
    query(5*256+128, 7*256+64, mk(2560, 0, 0, 0), 7);
    chk("reads_count", rd_q.size(), 4);
    if (rd_q.size() == 4) begin
      chk("read_m00", rd_q[0], 7*64+5);
      chk("read_m10", rd_q[1], 7*64+6);
      chk("read_m01", rd_q[2], 8*64+5);
      chk("read_m11", rd_q[3], 8*64+6);
    end

    // Step in x: (3.25,3.0)
    fill(0);
    mem[3][4] = 8'sd100; mem[4][4] = 8'sd100;
    query(3*256+64, 3*256, mk(6400, 25600, 0, 0), 7);

    // Most negative corner at integer point
    fill(0);
    mem[3][3] = -8'sd128;
    query(3*256, 3*256, mk(-32768, 32768, 32768, 0), 7);

    // Negative result truncated toward -inf: -65025/256 -> -255
    fill(0);
    mem[10][10] = -8'sd1;
    query(10*256+1, 10*256+1, mk(-255, 255, 255, 0), 7);

    // Out of bounds in x and in y: immediate response, no grid reads
    r0 = reads_seen;
    query(63*256, 0, mk(0, 0, 0, 1), 1);
    query(0, 63*256+5, mk(0, 0, 0, 1), 1);
    query(62*256+255, 62*256+255, mk(0, 0, 0, 0), 7);  // last in-grid cell, all zero
    chk("oob_no_reads", reads_seen - r0, 4);

    // Back-pressure: hold resp_ready low 5 cycles with a second query waiting
    fill(0);
    mem[3][4] = 8'sd100; mem[4][4] = 8'sd100;
    mem[10][10] = -8'sd1;
    resp_ready = 1'b0;
    sb.push_back(mk(6400, 25600, 0, 0));
    point_x = 14'(3*256+64); point_y = 14'(3*256); req_valid = 1'b1;
    wait_accept();
    point_x = 14'(10*256+1); point_y = 14'(10*256+1);   // held pending while busy
    wait_resp(lat);
    chk("stall_latency", lat, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_valid", resp_valid, 1);
      chk("stall_value", value, 6400);
      chk("stall_grad_x", grad_x, 25600);
      chk("stall_req_ready", req_ready, 0);
    end
    sb.push_back(mk(-255, 255, 255, 0));
    @(posedge clock); #1;
    resp_ready = 1'b1;
    @(posedge clock); #1;                 // consume edge
    chk("post_consume_ready", req_ready, 1);
    @(posedge clock); #1;                 // second query accepted here
    chk("second_accepted", req_ready, 0);
    req_valid = 1'b0;
    wait_resp(lat);
    chk("second_latency", lat, 7);
    wait_idle();

    // Reset during FETCH2 drops the query
    fill(10);
    sb.push_back(mk(2560, 0, 0, 0));
    point_x = 14'(5*256+128); point_y = 14'(7*256+64); req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    chk("fetch2_read", grid_read, 1);
    chk("fetch2_x", grid_x, 5);
    chk("fetch2_y", grid_y, 8);
    reset = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("mid_rst_grid_read", grid_read, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_grid_y", grid_y, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    @(posedge clock); @(posedge clock); #2;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("no_stale_resp", resp_valid, 0);
    end
    chk("post_rst_ready", req_ready, 1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
